// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch DRAM responder.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } ifr_state_t;

  localparam int LINE_OFF_W   = 3;
  localparam int WORD_SEL_BIT = 2;

  // Little-endian word pick from a 64-bit line: hi=0 -> [31:0], hi=1 -> [63:32].
  function automatic logic [31:0] sel_word(input logic [63:0] line, input logic hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ifetch_line_buf.sv
// One-entry, two-instruction line buffer with tag compare and
// invalidate-over-fill priority.
module ifetch_line_buf
  import ifetch_pkg::*;
#(
  parameter int TAG_W = 61
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             word_sel,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data,
  input  logic             inv,
  output logic             hit,
  output logic [31:0]      word
);

  logic             lb_valid;
  logic [TAG_W-1:0] lb_tag;
  logic [63:0]      lb_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lb_valid <= 1'b0;
      lb_tag   <= '0;
      lb_data  <= '0;
    end else begin
      if (fill) begin
        lb_tag  <= fill_tag;
        lb_data <= fill_data;
      end
      // A fence.i landing on the fill cycle must leave the buffer empty.
      lb_valid <= inv ? 1'b0 : (fill | lb_valid);
    end
  end

  assign hit  = lb_valid && (lb_tag == lookup_tag);
  assign word = sel_word(lb_data, word_sel);

endmodule

// File: rtl/ifetch_dram_responder.sv
// Fetch-side DRAM responder: serves instruction fetches from a one-line
// buffer and refills it from backing memory over a req/ack read port.
module ifetch_dram_responder
  import ifetch_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  input  logic              inv,
  output logic [31:0]       dram_dout,
  output logic              dram_data_ready,
  output logic              fetch_fault,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - LINE_OFF_W;

  ifr_state_t  state;
  logic        req_word_hi;
  logic        ready_q;
  logic        fault_q;
  logic        hit;
  logic [31:0] hit_word;
  logic        fill;
  logic [31:0] fill_word;

  // Memory port handshake: mem_req rises the cycle after a miss is accepted
  // and stays high, with mem_addr frozen, until the single mem_ack cycle
  // that also carries mem_rdata; a raised request is never withdrawn, even
  // on flush, so the line is always consumed and written into the buffer.
  assign fill      = ((state == MISS) || (state == DRAIN)) && mem_ack;
  assign fill_word = sel_word(mem_rdata, req_word_hi);
  assign dbg_state = state;

  ifetch_line_buf #(.TAG_W(TAG_W)) u_line_buf (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (fetch_addr[ADDR_W-1:LINE_OFF_W]),
    .word_sel   (fetch_addr[WORD_SEL_BIT]),
    .fill       (fill),
    .fill_tag   (mem_addr[ADDR_W-1:LINE_OFF_W]),
    .fill_data  (mem_rdata),
    .inv        (inv),
    .hit        (hit),
    .word       (hit_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_word_hi <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      dram_dout   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req && !flush) begin
            req_word_hi <= fetch_addr[WORD_SEL_BIT];
            if (fetch_addr[1:0] != 2'b00) begin
              state     <= RESP;
              ready_q   <= 1'b1;
              fault_q   <= 1'b1;
              dram_dout <= '0;
            end else if (hit) begin
              state     <= RESP;
              ready_q   <= 1'b1;
              dram_dout <= hit_word;
            end else begin
              state    <= MISS;
              mem_req  <= 1'b1;
              mem_addr <= {fetch_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            end
          end
        end
        MISS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            dram_dout <= fill_word;
            if (flush) begin
              state <= IDLE;
            end else begin
              state   <= RESP;
              ready_q <= 1'b1;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The pulse itself is registered; a flush arriving in the response cycle
  // still has to kill it, so that one late gate sits on the output.
  assign dram_data_ready = ready_q & ~flush;
  assign fetch_fault     = fault_q & ~flush;

endmodule

// File: tb/tb_ifetch_dram_responder.sv
// Bench for ifetch_dram_responder: directed scenarios plus randomized
// fetch/flush/inv traffic checked against a transaction-level model.
module tb_ifetch_dram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic        flush = 1'b0;
  logic        inv_req = 1'b0;
  logic        inv_ack = 1'b0;
  logic        inv;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic [31:0] dram_dout;
  logic        dram_data_ready;
  logic        fetch_fault;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [1:0]  dbg_state;

  assign inv = inv_req | inv_ack;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] exp_q[$];

  // model of the line buffer, seen only at transaction level
  logic        m_valid = 1'b0;
  logic [60:0] m_tag = '0;
  logic        miss_allowed = 1'b0;
  logic [63:0] exp_line = '0;

  // memory agent controls and observations
  int          ack_delay = 0;
  logic        inv_on_ack = 1'b0;
  int          acks = 0;
  int          wait_cnt = 0;
  logic [63:0] last_ack_addr = '0;

  logic [31:0] last_dout = '0;
  logic        last_fault = 1'b0;
  int          last_lat = 0;

  ifetch_dram_responder #(.ADDR_W(64), .LINE_BYTES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .flush           (flush),
    .inv             (inv),
    .dram_dout       (dram_dout),
    .dram_data_ready (dram_data_ready),
    .fetch_fault     (fetch_fault),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_line(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0011_2233_4455_6677;
    return {a[31:0] ^ 32'hdead_beef, (a[31:0] * 32'h9e37_79b9) ^ a[63:32]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(dram_data_ready), 64'd0);
    chk({tag, "_fault"}, 64'(fetch_fault), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_dout"}, 64'(dram_dout), 64'd0);
  endtask

  // backing-memory agent: acks ack_delay cycles into each request
  initial begin
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      inv_ack = 1'b0;
      if (!reset) begin
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack       = 1'b1;
          mem_rdata     = mem_line(mem_addr);
          inv_ack       = inv_on_ack;
          last_ack_addr = mem_addr;
          acks++;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // scoreboard compare: every cycle out of reset
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset) begin
      if (dram_data_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: dout=%h fault=%b, required no pulse", dram_dout, fetch_fault);
        end else begin
          e = exp_q.pop_front();
          if ({fetch_fault, dram_dout} !== e) begin
            miscompares++;
            $display("FAIL response: fault=%b dout=%h, required fault=%b dout=%h",
                     fetch_fault, dram_dout, e[32], e[31:0]);
          end
        end
      end else if (fetch_fault !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL fault_without_pulse: fault=%b, required 0", fetch_fault);
      end
      if (mem_req) begin
        vectors++;
        if (!miss_allowed || mem_addr !== exp_line) begin
          miscompares++;
          $display("FAIL mem_req: mem_addr=%h allowed=%b, required mem_addr=%h on a miss",
                   mem_addr, miss_allowed, exp_line);
        end
      end
    end
  end

  // driver: one fetch; fi = 0 no flush, >0 flush in that cycle after accept, -1 random flush
  task automatic do_fetch(input logic [63:0] addr, input int d, input int fi_in, input logic inv_a);
    logic        fault, hit, done;
    logic [63:0] ln;
    int          lat, a0, fi;
    @(posedge clk); #1;
    fault = (addr[1:0] != 2'b00);
    hit   = !fault && m_valid && (m_tag == addr[63:3]);
    lat   = (fault || hit) ? 1 : 2 + d;
    fi    = (fi_in < 0) ? int'($urandom_range(1, lat)) : fi_in;
    ln    = mem_line({addr[63:3], 3'b000});
    ack_delay  = d;
    inv_on_ack = inv_a;
    if (!fault && !hit) begin
      miss_allowed = 1'b1;
      exp_line     = {addr[63:3], 3'b000};
      m_valid      = !inv_a;
      m_tag        = addr[63:3];
    end
    if (fi == 0) exp_q.push_back(fault ? {1'b1, 32'h0} : {1'b0, addr[2] ? ln[63:32] : ln[31:0]});
    a0         = acks;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    done       = 1'b0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(posedge clk); #1;
      flush = (fi != 0) && (i == fi);
      if (flush) fetch_req = 1'b0;
      if (fi == 0 && dram_data_ready) begin
        fetch_req  = 1'b0;
        last_lat   = i;
        last_dout  = dram_dout;
        last_fault = fetch_fault;
        done       = 1'b1;
      end else if (fi != 0 && i > fi && !mem_req) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: addr=%h no completion within 60 cycles", addr);
      fetch_req = 1'b0;
      flush     = 1'b0;
      exp_q.delete();
    end else if (fi == 0) begin
      chk("latency", 64'(last_lat), 64'(lat));
    end
    chk("ack_count", 64'(acks - a0), (fault || hit) ? 64'd0 : 64'd1);
    miss_allowed = 1'b0;
  endtask

  task automatic do_inv();
    @(posedge clk); #1;
    inv_req = 1'b1;
    m_valid = 1'b0;
    @(posedge clk); #1;
    inv_req = 1'b0;
  endtask

  task automatic reset_mid_miss(input logic [63:0] addr);
    @(posedge clk); #1;
    ack_delay    = 20;
    inv_on_ack   = 1'b0;
    miss_allowed = 1'b1;
    exp_line     = {addr[63:3], 3'b000};
    fetch_req    = 1'b1;
    fetch_addr   = addr;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_mem_req_before", 64'(mem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    fetch_req    = 1'b0;
    miss_allowed = 1'b0;
    m_valid      = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;

    // cold miss, upper word
    do_fetch(64'h8000_0004, 3, 0, 1'b0);
    chk("cold_miss_mem_addr", last_ack_addr, 64'h8000_0000);
    chk("cold_miss_dout", 64'(last_dout), 64'h0011_2233);
    chk("cold_miss_latency", 64'(last_lat), 64'd5);

    // hit after fill, lower word
    do_fetch(64'h8000_0000, 0, 0, 1'b0);
    chk("hit_dout", 64'(last_dout), 64'h4455_6677);
    chk("hit_latency", 64'(last_lat), 64'd1);

    // flush mid-miss, then the drained line must hit
    do_fetch(64'h8000_0010, 3, 2, 1'b0);
    chk("drain_ack_addr", last_ack_addr, 64'h8000_0010);
    do_fetch(64'h8000_0014, 0, 0, 1'b0);
    chk("drained_line_hit_latency", 64'(last_lat), 64'd1);

    // inv coincident with the fill ack
    do_fetch(64'h8000_0020, 1, 0, 1'b1);
    chk("inv_fill_latency", 64'(last_lat), 64'd3);
    do_fetch(64'h8000_0024, 0, 0, 1'b0);
    chk("inv_fill_remiss_latency", 64'(last_lat), 64'd2);

    // misaligned PC
    do_fetch(64'h8000_0002, 0, 0, 1'b0);
    chk("misaligned_fault", 64'(last_fault), 64'd1);
    chk("misaligned_dout", 64'(last_dout), 64'd0);

    // reset during MISS, then a previously resident line misses
    do_fetch(64'h8000_0030, 0, 0, 1'b0);
    reset_mid_miss(64'h8000_0038);
    do_fetch(64'h8000_0030, 1, 0, 1'b0);
    chk("post_reset_miss_latency", 64'(last_lat), 64'd3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 64'h1_8000_0000 : 64'h8000_0000;
      a = a + 64'(8 * $urandom_range(0, 3)) + 64'(4 * $urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) do_inv();
      do_fetch(a, int'($urandom_range(0, 4)),
               ($urandom_range(0, 7) == 0) ? -1 : 0,
               ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
